serial_pair_transmitter_most_significant_first: RTL and testbench

SERIAL_PAIR_TRANSMITTER_MOST_SIGNIFICANT_FIRST -- requirements
Module: serial_pair_transmitter_most_significant_first

---
 rtl/serial_pair_transmitter_most_significant_first.sv | 84 ++++++++
 tb/tb_serial_pair_transmitter_most_significant_first.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_pair_transmitter_most_significant_first.sv
// Serialises a pair of WIDTH-bit words onto two 1-bit lanes, MSB first, with
// valid/ready handshakes on both sides and back-to-back reload on the last bit.
module serial_pair_transmitter_most_significant_first #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_b,
  output logic             out_first,
  output logic             out_last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  typedef enum logic {
    st_idle,
    st_shift
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_a_q, shift_a_d;
  logic [WIDTH-1:0]   shift_b_q, shift_b_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               last_bit;
  logic               accept;

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    bit_cnt_d = bit_cnt_q;

    last_bit = (state_q == st_shift) && (bit_cnt_q == '0);
    // Reload is allowed on the final consumed bit so a held stream has no bubble.
    in_ready = !rst && ((state_q == st_idle) || (last_bit && out_ready));
    accept   = in_valid && in_ready;

    if (accept) begin
      state_d   = st_shift;
      shift_a_d = in_a;
      shift_b_d = in_b;
      bit_cnt_d = CNT_TOP;
    end else if ((state_q == st_shift) && out_ready) begin
      if (bit_cnt_q != '0) begin
        shift_a_d = shift_a_q << 1;
        shift_b_d = shift_b_q << 1;
        bit_cnt_d = bit_cnt_q - CNT_W'(1);
      end else begin
        state_d = st_idle;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q   <= st_idle;
      shift_a_q <= '0;
      shift_b_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign out_valid = (state_q == st_shift);
  assign out_a     = out_valid && shift_a_q[WIDTH-1];
  assign out_b     = out_valid && shift_b_q[WIDTH-1];
  assign out_first = out_valid && (bit_cnt_q == CNT_TOP);
  assign out_last  = out_valid && (bit_cnt_q == '0);

endmodule

// File: tb/tb_serial_pair_transmitter_most_significant_first.sv
// Scoreboard bench: accepted pairs expand into expected bit-pair queues that
// per-instance monitors compare against the serial outputs (WIDTH=8 and WIDTH=1).
module tb_serial_pair_transmitter_most_significant_first;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b;
  logic       out_a, out_b, out_first, out_last;

  logic       in_valid_w1, in_ready_w1, out_valid_w1, out_ready_w1;
  logic [0:0] in_a_w1, in_b_w1;
  logic       out_a_w1, out_b_w1, out_first_w1, out_last_w1;

  serial_pair_transmitter_most_significant_first #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_first(out_first), .out_last(out_last)
  );

  serial_pair_transmitter_most_significant_first #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_w1), .in_ready(in_ready_w1), .in_a(in_a_w1), .in_b(in_b_w1),
    .out_valid(out_valid_w1), .out_ready(out_ready_w1), .out_a(out_a_w1), .out_b(out_b_w1),
    .out_first(out_first_w1), .out_last(out_last_w1)
  );

  typedef struct packed {
    logic a;
    logic b;
    logic first;
    logic last;
  } pair_t;

  pair_t q8[$];
  pair_t q1[$];
  int    n_checks   = 0;
  int    n_fail     = 0;
  int    valid_cnt8 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle monitors: inputs and outputs are stable here for the coming edge.
  always @(negedge clk) begin
    pair_t e;
    if (out_valid) valid_cnt8++;
    if (rst) begin
      q8.delete();
      check("w8_ready_in_reset", 32'(in_ready), 32'd0);
    end else begin
      check("w8_in_ready", 32'(in_ready),
            32'((q8.size() == 0) || (q8.size() == 1 && out_ready)));
      if (q8.size() > 0) begin
        e = q8[0];
        check("w8_bit_pair", {out_valid, out_a, out_b, out_first, out_last},
              {1'b1, e.a, e.b, e.first, e.last});
        if (out_ready) void'(q8.pop_front());
      end else begin
        check("w8_idle_outputs", {out_valid, out_a, out_b, out_first, out_last}, 32'd0);
      end
      if (in_valid && in_ready)
        for (int i = 7; i >= 0; i--)
          q8.push_back({in_a[i], in_b[i], i == 7, i == 0});
    end
  end

  always @(negedge clk) begin
    pair_t e;
    if (rst) begin
      q1.delete();
      check("w1_ready_in_reset", 32'(in_ready_w1), 32'd0);
    end else begin
      check("w1_in_ready", 32'(in_ready_w1),
            32'((q1.size() == 0) || (q1.size() == 1 && out_ready_w1)));
      if (q1.size() > 0) begin
        e = q1[0];
        check("w1_bit_pair", {out_valid_w1, out_a_w1, out_b_w1, out_first_w1, out_last_w1},
              {1'b1, e.a, e.b, e.first, e.last});
        if (out_ready_w1) void'(q1.pop_front());
      end else begin
        check("w1_idle_outputs", {out_valid_w1, out_a_w1, out_b_w1, out_first_w1, out_last_w1},
              32'd0);
      end
      if (in_valid_w1 && in_ready_w1)
        q1.push_back({in_a_w1[0], in_b_w1[0], 2'b11});
    end
  end

  initial begin
    int c0;
    // NOTE: bench inputs are driven with blocking assignments just after the edge, never at it.
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    in_valid_w1 = 1'b0; in_a_w1 = '0; in_b_w1 = '0; out_ready_w1 = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    #1;
    check("reset_outputs", {out_valid, out_a, out_b, out_first, out_last}, 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Single word, no stalls.
    c0 = valid_cnt8;
    in_valid = 1'b1; in_a = 8'h64; in_b = 8'h62;
    step();
    in_valid = 1'b0;
    check("first_latency", {out_valid, out_first, out_last}, 32'b110);
    repeat (9) step();
    check("single_word_len", 32'(valid_cnt8 - c0), 32'd8);
    check("single_word_done", 32'(out_valid), 32'd0);

    // Back-to-back words with in_valid held.
    c0 = valid_cnt8;
    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h5A;
    step();
    in_a = 8'hFF; in_b = 8'h00;
    repeat (8) step();
    in_valid = 1'b0;
    check("b2b_second_first", {out_valid, out_a, out_b, out_first}, 32'b1101);
    repeat (9) step();
    check("b2b_len", 32'(valid_cnt8 - c0), 32'd16);

    // Two-cycle stall while bit 4 is shown.
    c0 = valid_cnt8;
    in_valid = 1'b1; in_a = 8'h64; in_b = 8'h62;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b0;
    repeat (2) step();
    out_ready = 1'b1;
    repeat (6) step();
    check("stall_len", 32'(valid_cnt8 - c0), 32'd10);

    // Busy reject: second pair offered from the first bit onward.
    c0 = valid_cnt8;
    in_valid = 1'b1; in_a = 8'h64; in_b = 8'h62;
    step();
    in_a = 8'h11; in_b = 8'h22;
    check("busy_not_ready", 32'(in_ready), 32'd0);
    repeat (8) step();
    in_valid = 1'b0;
    repeat (9) step();
    check("busy_len", 32'(valid_cnt8 - c0), 32'd16);

    // Reset in the middle of a word.
    in_valid = 1'b1; in_a = 8'h64; in_b = 8'h62;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("midreset_outputs", {out_valid, out_a, out_b, out_first, out_last}, 32'd0);
    check("midreset_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("midreset_ready_high", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = 8'h01; in_b = 8'h80;
    step();
    in_valid = 1'b0;
    check("midreset_fresh_word", {out_valid, out_a, out_b, out_first, out_last}, 32'b10110);
    repeat (9) step();

    // WIDTH=1: one pair per cycle with in_valid held.
    in_valid_w1 = 1'b1; in_a_w1 = 1'b1; in_b_w1 = 1'b0;
    step();
    check("w1_single_pair", {out_valid_w1, out_a_w1, out_b_w1, out_first_w1, out_last_w1},
          32'b11011);
    check("w1_ready_each_cycle", 32'(in_ready_w1), 32'd1);
    in_a_w1 = 1'b0; in_b_w1 = 1'b1;
    step();
    check("w1_next_pair", {out_valid_w1, out_a_w1, out_b_w1, out_first_w1, out_last_w1},
          32'b10111);
    in_valid_w1 = 1'b0;
    step();

    // Random traffic on both instances, with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      in_valid     = $urandom_range(0, 1);
      in_a         = 8'($urandom);
      in_b         = 8'($urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      in_valid_w1  = $urandom_range(0, 1);
      in_a_w1      = 1'($urandom);
      in_b_w1      = 1'($urandom);
      out_ready_w1 = ($urandom_range(0, 3) != 0);
      step();
    end

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_valid_w1 = 1'b0; out_ready_w1 = 1'b1;
    repeat (12) step();
    check("drain_w8", 32'(q8.size()), 32'd0);
    check("drain_w1", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
